seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, meaning clk cycles per digit slot; legal range 1..65535.
REQ-002 The block SHALL have parameter GAP, default 500, meaning blanking cycles at the start of each slot; legal range 0..DIV-1, used only with BLANK_GAP_EN.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  scan enable; low blanks the display and freezes scanning.
REQ-006 The block SHALL have ports code7..code0  input  8 each  segment codes from the upstream shift stage, active-low, bit7 = dp.
REQ-007 The block SHALL have port an  output  8  digit enables, active-low; an[i] drives digit i.
REQ-008 The block SHALL have port seg  output  8  segment drive, active-low, copied from the selected code.
REQ-009 The block SHALL have port frame_done  output  1  one-cycle pulse at the end of each full 8-digit frame.

Function
REQ-010 The prescaler cnt SHALL count 0..DIV-1 while en=1, hold while en=0, and wrap to 0; tick = en & (cnt==DIV-1); DIV=1 gives tick on every enabled cycle.
REQ-011 The digit index idx (3 bits) SHALL advance by 1 on each tick and wrap from 7 to 0; it SHALL hold when tick=0.
REQ-012 The block SHALL hold an 8x8 shadow register; the displayed value of digit i SHALL come only from shadow[i], never directly from code inputs.
REQ-013 The shadow SHALL load all eight codes on (a) a tick with idx==7, or (b) the first cycle with en=1 while load_pending=1; load_pending SHALL be set by reset and cleared by the load.
REQ-014 Input code changes between loads SHALL NOT affect the display until the next load (tear-free frames).
REQ-015 an and seg SHALL be registered: the value at edge n+1 reflects en, idx, cnt and shadow at edge n (one-cycle latency).
REQ-016 With en=1 and no blanking active, an SHALL equal ~(8'b1 << idx) and seg SHALL equal shadow[idx].
REQ-017 With en=0, an SHALL be 8'hFF and seg SHALL be 8'hFF on the following cycle; idx and cnt SHALL resume from their held values when en returns to 1.
REQ-018 frame_done SHALL be registered and high for exactly one cycle following each tick with idx==7; it SHALL never assert while en=0.
REQ-019 Exactly zero or one bit of an SHALL be low in every cycle.

Reset
REQ-020 While rst=1 at a clock edge, the following cycle SHALL show an=8'hFF, seg=8'hFF, frame_done=0, with cnt=0, idx=0, every shadow entry=8'hFF, and load_pending=1.
REQ-021 rst SHALL take priority over en and tick; reset asserted mid-frame SHALL abandon the frame without issuing frame_done.

Configuration
REQ-022 The block SHALL use macro SEG7_BLANK_GAP_EN; when defined, an SHALL be 8'hFF and seg SHALL be 8'hFF whenever cnt<GAP (anti-ghosting), with all other behaviour unchanged.
REQ-023 When SEG7_BLANK_GAP_EN is undefined, GAP SHALL be ignored, no blanking logic SHALL be synthesised, and each digit SHALL be driven for all DIV cycles of its slot.

Verification (DIV=4, GAP=1 unless stated; code_i = 8'hC0+i)
REQ-024 The bench SHALL apply rst=1 for 2 cycles with en=1 -> an=FF, seg=FF, frame_done=0 throughout, and the first cycle after release still shows FF.
REQ-025 The bench SHALL release reset with en=1 and the macro undefined -> an=FE/seg=C0 for 4 cycles, then FD/C1, and so on to 7F/C7; frame_done SHALL pulse once every 32 cycles.
REQ-026 The bench SHALL change code3 to 8'h99 while idx=1 -> digit3 shows C3 in the current frame and 99 from the next frame.
REQ-027 The bench SHALL drop en for 5 cycles during the 2nd cycle of digit 5 -> an=FF/seg=FF after one cycle; on re-enable, digit 5 SHALL complete its remaining 2 cycles before digit 6 starts.
REQ-028 The bench SHALL pulse rst during digit 6 -> no frame_done is issued, and after release digit 0 restarts with a fresh snapshot of the current codes.
REQ-029 The bench SHALL run with SEG7_BLANK_GAP_EN defined -> the first cycle of every slot shows an=FF, the next 3 cycles show the digit, and the frame period stays at 32 cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit seven-segment scan driver with tear-free shadow codes.
// Optional anti-ghost blanking at the start of each slot: define SEG7_BLANK_GAP_EN.
module seg7_scan_driver #(
  parameter int DIV = 50000,
  parameter int GAP = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] code7,
  input  logic [7:0] code6,
  input  logic [7:0] code5,
  input  logic [7:0] code4,
  input  logic [7:0] code3,
  input  logic [7:0] code2,
  input  logic [7:0] code1,
  input  logic [7:0] code0,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       frame_done
);

`ifdef SEG7_BLANK_GAP_EN
  localparam bit gap_en = 1'b1;
`else
  localparam bit gap_en = 1'b0;
`endif

  localparam logic [15:0] cnt_last = 16'(DIV - 1);

  logic [7:0]  code_w [8];
  logic [7:0]  shadow_reg [8];
  logic [15:0] cnt_reg;
  logic [2:0]  idx_reg;
  logic        load_pending_reg;
  logic [7:0]  an_reg;
  logic [7:0]  seg_reg;
  logic        frame_done_reg;

  logic run;
  logic tick;
  logic wrap;
  logic load;
  logic blank;

  assign code_w[0] = code0;
  assign code_w[1] = code1;
  assign code_w[2] = code2;
  assign code_w[3] = code3;
  assign code_w[4] = code4;
  assign code_w[5] = code5;
  assign code_w[6] = code6;
  assign code_w[7] = code7;

  // The priming cycle that captures the first snapshot after reset is shown
  // blank and does not consume a prescaler count, so digit 0 still gets a
  // full slot of valid shadow data.
  assign run  = en & ~load_pending_reg;
  assign tick = run & (cnt_reg == cnt_last);
  assign wrap = tick & (idx_reg == 3'd7);
  assign load = (en & load_pending_reg) | wrap;

  generate
    if (GAP > 0 && gap_en) begin : g_gap
      assign blank = (cnt_reg < 16'(GAP));
    end else begin : g_no_gap
      assign blank = 1'b0;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg[gi] <= 8'hFF;
        end else if (load) begin
          shadow_reg[gi] <= code_w[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg          <= 16'd0;
      idx_reg          <= 3'd0;
      load_pending_reg <= 1'b1;
      an_reg           <= 8'hFF;
      seg_reg          <= 8'hFF;
      frame_done_reg   <= 1'b0;
    end else begin
      if (run) begin
        cnt_reg <= tick ? 16'd0 : cnt_reg + 16'd1;
      end
      if (tick) begin
        idx_reg <= idx_reg + 3'd1;
      end
      if (load) begin
        load_pending_reg <= 1'b0;
      end
      frame_done_reg <= wrap;
      if (run && !blank) begin
        an_reg  <= ~(8'b1 << idx_reg);
        seg_reg <= shadow_reg[idx_reg];
      end else begin
        an_reg  <= 8'hFF;
        seg_reg <= 8'hFF;
      end
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIV=4, GAP=1); honours SEG7_BLANK_GAP_EN.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int GAP   = 1;
  localparam int FRAME = 8 * DIV;
`ifdef SEG7_BLANK_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] code [8];
  logic [7:0] an;
  logic [7:0] seg;
  logic       frame_done;

  exp_t sb[$];
  int   fd_times[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  int   df_cnt = 0;
  int   fd_cnt = 0;
  logic [7:0] d3_seg = 8'h00;
  logic [7:0] d0_seg = 8'h00;

  // reference model: position within the 32-cycle frame plus a frame snapshot
  int         m_pos = 0;
  bit         m_pend = 1'b1;
  logic [7:0] m_snap [8];

  seg7_scan_driver #(.DIV(DIV), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .en(en),
    .code7(code[7]), .code6(code[6]), .code5(code[5]), .code4(code[4]),
    .code3(code[3]), .code2(code[2]), .code1(code[1]), .code0(code[0]),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_step(output exp_t e);
    int d;
    int s;
    bit blank;
    e.an  = 8'hFF;
    e.seg = 8'hFF;
    e.fd  = 1'b0;
    if (rst) begin
      m_pos  = 0;
      m_pend = 1'b1;
      foreach (m_snap[i]) m_snap[i] = 8'hFF;
    end else if (en && m_pend) begin
      m_pend = 1'b0;
      foreach (m_snap[i]) m_snap[i] = code[i];
    end else if (en) begin
      d = m_pos / DIV;
      s = m_pos % DIV;
      blank = GAP_ON && (s < GAP);
      if (!blank) begin
        e.an  = ~8'(1 << d);
        e.seg = m_snap[d];
      end
      e.fd  = (m_pos == FRAME - 1);
      m_pos = (m_pos + 1) % FRAME;
      if (m_pos == 0) foreach (m_snap[i]) m_snap[i] = code[i];
    end
  endtask

  task automatic cyc();
    exp_t e;
    exp_t p;
    model_step(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc_n++;
    p = sb.pop_front();
    chk("an", an, p.an);
    chk("seg", seg, p.seg);
    chk("frame_done", frame_done, p.fd);
    chk("an_onehot", 32'($countones(~an) <= 1), 1);
    if (an === 8'hF7) d3_seg = seg;
    if (an === 8'hFE) d0_seg = seg;
    if (an === 8'hDF) df_cnt++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_times.push_back(cyc_n);
    end
    $display("cyc=%0d rst=%b en=%b an=%h seg=%h fd=%b", cyc_n, rst, en, an, seg, frame_done);
  endtask

  task automatic run_to(input int target);
    int k = 0;
    while ((m_pos != target || m_pend) && k < 200) begin
      cyc();
      k++;
    end
    chk("run_to_bound", m_pos, target);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 8; i++) code[i] = 8'(8'hC0 + i);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("prime_an", an, 8'hFF);

    run_to(1 * DIV);
    code[3] = 8'h99;
    run_to(4 * DIV);
    chk("d3_old", d3_seg, 8'hC3);
    run_to(0);
    run_to(4 * DIV);
    chk("d3_new", d3_seg, 8'h99);

    run_to(5 * DIV + 2);
    en = 1'b0;
    repeat (5) cyc();
    chk("pause_an", an, 8'hFF);
    en = 1'b1;
    df_cnt = 0;
    repeat (3) cyc();
    chk("d5_resume", df_cnt, 2);

    code[0] = 8'h5A;
    fd_cnt = 0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run_to(2 * DIV);
    chk("rst_no_fd", fd_cnt, 0);
    chk("d0_fresh", d0_seg, 8'h5A);

    fd_times.delete();
    repeat (80) cyc();
    chk("fd_count", fd_times.size(), 2);
    if (fd_times.size() >= 2) chk("fd_period", fd_times[1] - fd_times[0], 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc_n);
    $fatal(1, "watchdog expired");
  end

endmodule
